fft_ram_sequencer: RTL

FFT_RAM_SEQUENCER -- requirements
Module: fft_ram_sequencer

---
 rtl/fft_pkg.sv | 20 ++
 rtl/fft_bf_addr_gen.sv | 34 +++
 rtl/fft_ram_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and constant helpers for the FFT RAM sequencer.
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        FINISH
    } fft_state_e;

    // Ceiling log2, usable in parameter and localparam expressions.
    function automatic int unsigned log2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Radix-2 DIT butterfly address and twiddle-index generator, combinational from (stage, butterfly).
module fft_bf_addr_gen
    import fft_pkg::*;
#(
    parameter int N  = 32,
    parameter int AW = $clog2(N),
    parameter int SW = 3
) (
    input  logic [SW-1:0] s_i,
    input  logic [AW-2:0] k_i,
    output logic [AW-1:0] addr1_o,
    output logic [AW-1:0] addr2_o,
    output logic [AW-2:0] tw_idx_o
);

    localparam int unsigned L = log2_f(N);

    logic [AW-1:0] span;
    logic [AW-1:0] pos;
    logic [AW-1:0] grp;
    int unsigned   s_u;

    // span is a power of two, so mod/div reduce to mask/shift and +span to an OR.
    always_comb begin
        s_u      = 32'(s_i);
        span     = AW'(1) << s_u;
        pos      = AW'(k_i) & (span - AW'(1));
        grp      = AW'(k_i) >> s_u;
        addr1_o  = (grp << (s_u + 1)) | pos;
        addr2_o  = addr1_o | span;
        tw_idx_o = pos[AW-2:0] << (L - 1 - s_u);
    end

endmodule

// File: rtl/fft_ram_sequencer.sv
// In-place radix-2 FFT RAM sequencer: walks every butterfly of every stage as READ/WAIT/WRITE.
module fft_ram_sequencer
    import fft_pkg::*;
#(
    parameter int N      = 32,
    parameter int BF_LAT = 2,
    parameter int AW     = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] address1,
    output logic [AW-1:0] address2,
    output logic          sel,
    output logic          wr_en,
    output logic          bf_start,
    output logic [AW-2:0] tw_idx
);

    localparam int unsigned     L      = log2_f(N);
    localparam int              SW     = (L > 1) ? $clog2(L) : 1;
    localparam int              WW     = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam logic [AW-2:0]   K_LAST = (AW-1)'(N / 2 - 1);
    localparam logic [SW-1:0]   S_LAST = SW'(L - 1);
    localparam logic [WW-1:0]   W_LAST = WW'(BF_LAT - 1);

    fft_state_e    state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [AW-2:0] k_q, k_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0] a1_q, a1_d, a2_q, a2_d;
    logic [AW-2:0] tw_q, tw_d;
    logic [AW-1:0] gen_a1, gen_a2;
    logic [AW-2:0] gen_tw;

    fft_bf_addr_gen #(
        .N (N),
        .AW(AW),
        .SW(SW)
    ) u_addr_gen (
        .s_i     (s_d),
        .k_i     (k_d),
        .addr1_o (gen_a1),
        .addr2_o (gen_a2),
        .tw_idx_o(gen_tw)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            READ: begin
                state_d = WAIT;
                wcnt_d  = '0;
            end
            WAIT: begin
                if (wcnt_q == W_LAST) state_d = WRITE;
                else                  wcnt_d  = wcnt_q + WW'(1);
            end
            WRITE: begin
                if (k_q != K_LAST) begin
                    k_d     = k_q + (AW-1)'(1);
                    state_d = READ;
                end else if (s_q != S_LAST) begin
                    s_d     = s_q + SW'(1);
                    k_d     = '0;
                    state_d = READ;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
                s_d     = '0;
                k_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Addresses are captured from the next (s,k) on entry to READ and held through WRITE.
    always_comb begin
        a1_d = a1_q;
        a2_d = a2_q;
        tw_d = tw_q;
        case (state_d)
            READ: begin
                a1_d = gen_a1;
                a2_d = gen_a2;
                tw_d = gen_tw;
            end
            WAIT, WRITE: ;
            default: begin
                a1_d = '0;
                a2_d = '0;
                tw_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            wcnt_q  <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            wcnt_q  <= wcnt_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            tw_q    <= tw_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FINISH);
    assign sel      = (state_q == READ) || (state_q == WRITE);
    assign wr_en    = (state_q == WRITE);
    assign bf_start = (state_q == WAIT) && (wcnt_q == '0);
    assign address1 = a1_q;
    assign address2 = a2_q;
    assign tw_idx   = tw_q;

endmodule
